// File: rtl/spi_master_param.sv
// SPI master with parameterised word width, SCLK divider, SPI mode, bit order and chip-select count.
// Latency: a start accepted at cycle T0 keeps busy high for CLK_DIV*(2*DATA_WIDTH+2) cycles; done pulses the cycle after.
// Backpressure: start is ignored while busy_o=1; a start in the done cycle (busy_o=0) is accepted.
module spi_master_param #(
    parameter int DATA_WIDTH = 16,
    parameter int CLK_DIV    = 2,
    parameter bit CPOL       = 1'b0,
    parameter bit CPHA       = 1'b0,
    parameter bit MSB_FIRST  = 1'b1,
    parameter int NUM_CS     = 2,
    localparam int CSW       = $clog2(NUM_CS),
    localparam int CW        = $clog2(DATA_WIDTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [DATA_WIDTH-1:0] tx_data_i,
    input  logic [CSW-1:0]        cs_sel_i,
    input  logic                  spi_miso_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] rx_data_o,
    output logic                  spi_sclk_o,
    output logic                  spi_mosi_o,
    output logic [NUM_CS-1:0]     spi_cs_l_o,
    output logic [CW-1:0]         counter_o
);
    localparam int              HW        = $clog2(2 * DATA_WIDTH);
    localparam logic [7:0]      DIV_LAST  = 8'(CLK_DIV - 1);
    localparam logic [HW-1:0]   HALF_LAST = HW'(2 * DATA_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_e;

    state_e                  state_q, state_d;
    logic [7:0]              div_q, div_d;
    logic [HW-1:0]           half_q, half_d;
    logic                    sclk_q, sclk_d;
    logic                    mosi_q, mosi_d;
    logic                    done_q, done_d;
    logic [NUM_CS-1:0]       cs_q, cs_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   txsh_q, txsh_d;
    logic [DATA_WIDTH-1:0]   rxsh_q, rxsh_d;
    logic [DATA_WIDTH-1:0]   rx_q, rx_d;
    logic                    div_end;
    logic                    edge_v;
    logic                    edge_odd;

    // Next-state logic: sequencing through the four phases plus SCLK edge actions.
    // Edge k (k = 0 .. 2*DATA_WIDTH-1) opens half-period k of SHIFT; even k is a leading edge.
    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        half_d   = half_q;
        sclk_d   = sclk_q;
        mosi_d   = mosi_q;
        done_d   = 1'b0;
        cs_d     = cs_q;
        cnt_d    = cnt_q;
        txsh_d   = txsh_q;
        rxsh_d   = rxsh_q;
        rx_d     = rx_q;
        edge_v   = 1'b0;
        edge_odd = 1'b0;
        div_end  = (div_q == DIV_LAST);

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = SETUP;
                    div_d   = '0;
                    half_d  = '0;
                    cnt_d   = CW'(DATA_WIDTH);
                    rxsh_d  = '0;
                    // Out-of-range selects match no index, so every chip select stays high.
                    for (int i = 0; i < NUM_CS; i++) begin
                        cs_d[i] = (int'(cs_sel_i) != i);
                    end
                    if (!CPHA) begin
                        // First bit must already be on the line before the first leading edge.
                        mosi_d = MSB_FIRST ? tx_data_i[DATA_WIDTH-1] : tx_data_i[0];
                        txsh_d = MSB_FIRST ? (tx_data_i << 1) : (tx_data_i >> 1);
                    end else begin
                        mosi_d = 1'b0;
                        txsh_d = tx_data_i;
                    end
                end
            end
            SETUP: begin
                if (div_end) begin
                    state_d  = SHIFT;
                    div_d    = '0;
                    half_d   = '0;
                    edge_v   = 1'b1;
                    edge_odd = 1'b0;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            SHIFT: begin
                if (div_end) begin
                    div_d = '0;
                    if (half_q == HALF_LAST) begin
                        // SCLK already returned to idle at the start of this last half.
                        state_d = HOLD;
                    end else begin
                        half_d   = half_q + HW'(1);
                        edge_v   = 1'b1;
                        edge_odd = ~half_q[0];
                    end
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            HOLD: begin
                if (div_end) begin
                    state_d = IDLE;
                    div_d   = '0;
                    cs_d    = '1;
                    done_d  = 1'b1;
                    rx_d    = rxsh_q;
                    mosi_d  = 1'b0;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (edge_v) begin
            sclk_d = ~sclk_q;
            if (edge_odd == CPHA) begin
                // Sample edge: leading for CPHA=0, trailing for CPHA=1.
                rxsh_d = MSB_FIRST ? {rxsh_q[DATA_WIDTH-2:0], spi_miso_i}
                                   : {spi_miso_i, rxsh_q[DATA_WIDTH-1:1]};
                cnt_d  = cnt_q - CW'(1);
            end else begin
                // Launch edge: present the next bit.
                mosi_d = MSB_FIRST ? txsh_q[DATA_WIDTH-1] : txsh_q[0];
                txsh_d = MSB_FIRST ? (txsh_q << 1) : (txsh_q >> 1);
            end
        end
    end

    // State and datapath registers; reset aborts any transfer without a done pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            div_q   <= '0;
            half_q  <= '0;
            sclk_q  <= CPOL;
            mosi_q  <= 1'b0;
            done_q  <= 1'b0;
            cs_q    <= '1;
            cnt_q   <= '0;
            txsh_q  <= '0;
            rxsh_q  <= '0;
            rx_q    <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            half_q  <= half_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            done_q  <= done_d;
            cs_q    <= cs_d;
            cnt_q   <= cnt_d;
            txsh_q  <= txsh_d;
            rxsh_q  <= rxsh_d;
            rx_q    <= rx_d;
        end
    end

    assign busy_o     = (state_q != IDLE);
    assign done_o     = done_q;
    assign rx_data_o  = rx_q;
    assign spi_sclk_o = sclk_q;
    assign spi_mosi_o = mosi_q;
    assign spi_cs_l_o = cs_q;
    assign counter_o  = cnt_q;
endmodule

// File: tb/tb_spi_master_param.sv
// Bench for spi_master_param: four instances (default mode, CPOL1/CPHA1/LSB-first 8-bit, CLK_DIV=1, CLK_DIV=5).
// Expected words, timings and chip-select patterns come from the transfer rules, not from DUT internals.
// Outputs are observed 1 time unit after the falling clock edge.
module tb_spi_master_param;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic bz [4];
    logic dn [4];
    logic sc [4];
    logic mo [4];

    logic        start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
    logic [15:0] tx0 = '0, tx2 = '0;
    logic [7:0]  tx1 = '0;
    logic [0:0]  sel0 = '0, sel2 = '0;
    logic [1:0]  sel1 = '0;
    logic        miso1 = 1'b0;
    logic [15:0] rx0, rx2, rx3;
    logic [7:0]  rx1;
    logic [1:0]  cs0, cs2, cs3;
    logic [2:0]  cs1;
    logic [4:0]  cnt0, cnt2, cnt3;
    logic [3:0]  cnt1;

    spi_master_param u0 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start0), .tx_data_i(tx0), .cs_sel_i(sel0),
        .spi_miso_i(mo[0]), .busy_o(bz[0]), .done_o(dn[0]), .rx_data_o(rx0),
        .spi_sclk_o(sc[0]), .spi_mosi_o(mo[0]), .spi_cs_l_o(cs0), .counter_o(cnt0));

    spi_master_param #(.DATA_WIDTH(8), .CLK_DIV(2), .CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b0), .NUM_CS(3)) u1 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start1), .tx_data_i(tx1), .cs_sel_i(sel1),
        .spi_miso_i(miso1), .busy_o(bz[1]), .done_o(dn[1]), .rx_data_o(rx1),
        .spi_sclk_o(sc[1]), .spi_mosi_o(mo[1]), .spi_cs_l_o(cs1), .counter_o(cnt1));

    spi_master_param #(.CLK_DIV(1)) u2 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start2), .tx_data_i(tx2), .cs_sel_i(sel2),
        .spi_miso_i(mo[2]), .busy_o(bz[2]), .done_o(dn[2]), .rx_data_o(rx2),
        .spi_sclk_o(sc[2]), .spi_mosi_o(mo[2]), .spi_cs_l_o(cs2), .counter_o(cnt2));

    spi_master_param #(.CLK_DIV(5)) u3 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start2), .tx_data_i(tx2), .cs_sel_i(sel2),
        .spi_miso_i(mo[3]), .busy_o(bz[3]), .done_o(dn[3]), .rx_data_o(rx3),
        .spi_sclk_o(sc[3]), .spi_mosi_o(mo[3]), .spi_cs_l_o(cs3), .counter_o(cnt3));

    // Monitor: busy length, done count/cycle, and MOSI captured at every rising SCLK while busy.
    // Rising SCLK is the sample edge of all four instances (leading for mode 0, trailing for mode 3).
    logic        bz_p [4] = '{default: 1'b0};
    logic        sc_p [4] = '{default: 1'b0};
    int          bcnt [4] = '{default: 0};
    int          nb   [4] = '{default: 0};
    int          dcnt [4] = '{default: 0};
    int          dcyc [4] = '{default: 0};
    logic [31:0] cap  [4] = '{default: 32'h0};

    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            bz_p[k] <= bz[k];
            sc_p[k] <= sc[k];
            if (bz[k] && !bz_p[k]) begin
                bcnt[k] <= 1;
                nb[k]   <= 0;
                cap[k]  <= '0;
            end else if (bz[k]) begin
                bcnt[k] <= bcnt[k] + 1;
            end
            if (dn[k]) begin
                dcnt[k] <= dcnt[k] + 1;
                dcyc[k] <= cyc;
            end
            if (bz[k] && sc[k] && !sc_p[k]) begin
                nb[k]  <= nb[k] + 1;
                cap[k] <= (k == 1) ? {24'h0, mo[k], cap[k][7:1]} : {cap[k][30:0], mo[k]};
            end
        end
    end

    // Mode-3 slave for u1: shifts its word out LSB-first on each leading (falling) SCLK edge.
    logic [7:0] slave_word = 8'h00;
    int         sidx       = 0;
    always @(negedge clk) begin
        if (bz[1] && !bz_p[1]) begin
            sidx <= 0;
        end else if (bz[1] && !sc[1] && sc_p[1] && sidx < 8) begin
            miso1 <= slave_word[sidx];
            sidx  <= sidx + 1;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input int k, input string tag);
        int n = 0;
        while (!dn[k] && n < 500) begin
            step();
            n++;
        end
        chk({tag, "_done_seen"}, 32'(dn[k]), 32'd1);
    endtask

    int t0;

    // Launch a default-mode transfer and check the T0+1 state; inputs are scrambled after accept.
    task automatic begin0(input logic [15:0] tx, input logic sel, input string tag);
        logic [1:0] exp_cs;
        exp_cs      = 2'b11;
        exp_cs[sel] = 1'b0;
        tx0 = tx; sel0 = sel; start0 = 1'b1; t0 = cyc;
        step();
        start0 = 1'b0; tx0 = ~tx; sel0 = ~sel;
        chk({tag, "_busy"}, 32'(bz[0]), 32'd1);
        chk({tag, "_cs"}, 32'(cs0), 32'(exp_cs));
        chk({tag, "_mosi_first"}, 32'(mo[0]), 32'(tx[15]));
        chk({tag, "_cnt_load"}, 32'(cnt0), 32'd16);
    endtask

    task automatic end0(input logic [15:0] tx, input string tag);
        wait_done(0, tag);
        chk({tag, "_done_cycle"}, 32'(cyc - t0), 32'd69);
        chk({tag, "_busy_len"}, 32'(bcnt[0]), 32'd68);
        chk({tag, "_pulses"}, 32'(nb[0]), 32'd16);
        chk({tag, "_mosi_word"}, cap[0], 32'(tx));
        chk({tag, "_rx"}, 32'(rx0), 32'(tx));
        chk({tag, "_cs_off"}, 32'(cs0), 32'h3);
        chk({tag, "_idle"}, {29'h0, bz[0], mo[0], sc[0]}, 32'h0);
        chk({tag, "_cnt_end"}, 32'(cnt0), 32'd0);
    endtask

    task automatic run1(input logic [7:0] tx, input logic [1:0] sel, input logic [7:0] sw, input string tag);
        logic [2:0] exp_cs;
        int         t1;
        exp_cs = 3'b111;
        if (sel < 2'd3) exp_cs[sel] = 1'b0;
        slave_word = sw; tx1 = tx; sel1 = sel; start1 = 1'b1; t1 = cyc;
        step();
        start1 = 1'b0; tx1 = ~tx; sel1 = ~sel;
        chk({tag, "_busy"}, 32'(bz[1]), 32'd1);
        chk({tag, "_cs"}, 32'(cs1), 32'(exp_cs));
        chk({tag, "_sclk_setup"}, 32'(sc[1]), 32'd1);
        wait_done(1, tag);
        chk({tag, "_done_cycle"}, 32'(cyc - t1), 32'd37);
        chk({tag, "_busy_len"}, 32'(bcnt[1]), 32'd36);
        chk({tag, "_mosi_word"}, cap[1], 32'(tx));
        chk({tag, "_rx"}, 32'(rx1), 32'(sw));
        chk({tag, "_sclk_idle"}, 32'(sc[1]), 32'd1);
        chk({tag, "_cs_off"}, 32'(cs1), 32'h7);
        chk({tag, "_cnt_end"}, 32'(cnt1), 32'd0);
    endtask

    task automatic run23(input logic [15:0] tx, input string tag);
        int n = 0;
        tx2 = tx; sel2 = 1'b0; start2 = 1'b1;
        step();
        start2 = 1'b0; tx2 = ~tx; sel2 = 1'b1;
        chk({tag, "_cs_div1"}, 32'(cs2), 32'h2);
        chk({tag, "_cs_div5"}, 32'(cs3), 32'h2);
        while ((bz[2] || bz[3]) && n < 500) begin
            step();
            n++;
        end
        chk({tag, "_finished"}, {30'h0, bz[2], bz[3]}, 32'h0);
        chk({tag, "_busy_div1"}, 32'(bcnt[2]), 32'd34);
        chk({tag, "_busy_div5"}, 32'(bcnt[3]), 32'd170);
        chk({tag, "_rx_div1"}, 32'(rx2), 32'(tx));
        chk({tag, "_rx_div5"}, 32'(rx3), 32'(tx));
        chk({tag, "_mosi_div5"}, cap[3], 32'(tx));
        chk({tag, "_pulses_div1"}, 32'(nb[2]), 32'd16);
        chk({tag, "_cnt_end"}, 32'({cnt2, cnt3}), 32'd0);
    endtask

    initial begin
        logic [15:0] wa, wb;
        int          dd;

        // Asynchronous reset: outputs must settle before any clock edge.
        #2 rst_n = 1'b0;
        #1;
        chk("rst_cs0", 32'(cs0), 32'h3);
        chk("rst_busy_done0", {30'h0, bz[0], dn[0]}, 32'h0);
        chk("rst_sclk_mosi0", {30'h0, sc[0], mo[0]}, 32'h0);
        chk("rst_rx_cnt0", {11'h0, rx0, cnt0}, 32'h0);
        chk("rst_sclk1", 32'(sc[1]), 32'd1);
        chk("rst_cs1", 32'(cs1), 32'h7);
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // Loopback reference transfer, with the counter tracked against observed sample edges.
        begin0(16'hA5C3, 1'b0, "ref");
        step(); step();
        chk("ref_first_sample", 32'(nb[0]), 32'd1);
        chk("ref_cnt_first", 32'(cnt0), 32'd15);
        repeat (32) step();
        chk("ref_cnt_mid", 32'(cnt0), 32'(16 - nb[0]));
        end0(16'hA5C3, "ref");
        dd = dcnt[0];
        step();
        chk("ref_done_single", 32'(dn[0]), 32'd0);
        chk("ref_rx_hold", 32'(rx0), 32'hA5C3);
        chk("ref_done_count", 32'(dcnt[0] - dd), 32'd0);

        // Random loopback words and selects.
        for (int i = 0; i < 3; i++) begin
            wa = 16'($urandom);
            begin0(wa, 1'($urandom_range(0, 1)), "rnd");
            end0(wa, "rnd");
            step();
        end

        // Start with new data mid-transfer must be ignored.
        wa = 16'($urandom);
        dd = dcnt[0];
        begin0(wa, 1'b0, "ign");
        repeat (19) step();
        start0 = 1'b1; tx0 = ~wa;
        step();
        start0 = 1'b0;
        chk("ign_busy", 32'(bz[0]), 32'd1);
        end0(wa, "ign");
        repeat (6) step();
        chk("ign_one_done", 32'(dcnt[0] - dd), 32'd1);
        chk("ign_no_restart", 32'(bz[0]), 32'd0);

        // Back-to-back on chip select 1, restarted in the done cycle.
        wa = 16'($urandom);
        wb = 16'($urandom);
        dd = dcnt[0];
        begin0(wa, 1'b1, "b2b1");
        end0(wa, "b2b1");
        begin0(wb, 1'b1, "b2b2");
        end0(wb, "b2b2");
        chk("b2b_done_count", 32'(dcnt[0] - dd), 32'd2);

        // Reset halfway through a transfer.
        wa = 16'($urandom);
        begin0(wa, 1'b0, "abort");
        repeat (33) step();
        #2 rst_n = 1'b0;
        #1;
        chk("abort_cs_async", 32'(cs0), 32'h3);
        chk("abort_busy_sclk_mosi", {29'h0, bz[0], sc[0], mo[0]}, 32'h0);
        chk("abort_rx_cnt", {11'h0, rx0, cnt0}, 32'h0);
        step();
        rst_n = 1'b1;
        dd = dcnt[0];
        repeat (80) step();
        chk("abort_no_done", 32'(dcnt[0] - dd), 32'd0);
        wa = 16'($urandom);
        begin0(wa, 1'b1, "fresh");
        end0(wa, "fresh");

        // Mode 3, LSB-first, 8-bit, external slave.
        run1(8'h96, 2'd0, 8'h3C, "m3");
        step();
        for (int i = 0; i < 4; i++) begin
            run1(8'($urandom), (i == 0) ? 2'd3 : 2'($urandom_range(0, 3)), 8'($urandom), "m3rnd");
            step();
        end

        // Divider extremes.
        run23(16'($urandom), "div");
        step();
        run23(16'($urandom), "div");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/spi_master_param.md
SPI_MASTER_PARAM -- requirements
Module: spi_master_param

Interface
REQ-001 Parameter DATA_WIDTH, default 16, sets bits per transfer (range 2..32).
REQ-002 Parameter CLK_DIV, default 2, sets the SCLK half-period in clk cycles (range 1..255).
REQ-003 Parameter CPOL, default 0, sets the SCLK idle level.
REQ-004 Parameter CPHA, default 0: 0 samples on the leading edge, 1 samples on the trailing edge.
REQ-005 Parameter MSB_FIRST, default 1: 1 shifts bit DATA_WIDTH-1 first, 0 shifts bit 0 first.
REQ-006 Parameter NUM_CS, default 2, sets the number of chip selects (range 2..8); CSW = $clog2(NUM_CS).
REQ-007 clk  input  1  single clock; all logic on the rising edge.
REQ-008 reset  input  1  asynchronous, active-low reset.
REQ-009 start  input  1  transfer request, sampled when busy=0.
REQ-010 tx_data  input  DATA_WIDTH  word to transmit, latched on accept.
REQ-011 cs_sel  input  CSW  target slave index, latched on accept.
REQ-012 spi_miso  input  1  serial data from the slave.
REQ-013 busy  output  1  high while a transfer is in progress.
REQ-014 done  output  1  single-cycle completion pulse.
REQ-015 rx_data  output  DATA_WIDTH  last received word.
REQ-016 spi_sclk, spi_mosi  output  1 each  serial clock and serial data.
REQ-017 spi_cs_l  output  NUM_CS  active-low chip selects, one-hot-low.
REQ-018 counter  output  $clog2(DATA_WIDTH+1)  bits remaining in the current transfer.

Function
REQ-019 The FSM SHALL have states IDLE, SETUP, SHIFT and HOLD.
- IDLE->SETUP on start=1.
- SETUP->SHIFT after CLK_DIV cycles.
- SHIFT->HOLD after 2*DATA_WIDTH half-periods.
- HOLD->IDLE after CLK_DIV cycles.
REQ-020 Accept: a start in IDLE (cycle T0) SHALL latch tx_data and cs_sel and load counter=DATA_WIDTH; busy=1 and spi_cs_l[cs_sel]=0 from T0+1.
REQ-021 start SHALL be ignored while busy=1; tx_data and cs_sel changes after accept SHALL have no effect.
REQ-022 Only the selected chip select SHALL be low; an out-of-range cs_sel SHALL assert no chip select, but the transfer SHALL still run.
REQ-023 spi_sclk SHALL equal CPOL in IDLE, SETUP and HOLD, and SHALL toggle every CLK_DIV cycles in SHIFT: DATA_WIDTH full periods, ending at CPOL.
REQ-024 CPHA=0: spi_mosi SHALL present the first bit from T0+1; sample on each leading edge; shift the next bit on each trailing edge.
REQ-025 CPHA=1: spi_mosi SHALL change on each leading edge; sample on each trailing edge.
REQ-026 counter SHALL decrement by 1 at each sample edge and reach 0 on the last sample.
REQ-027 spi_mosi SHALL be 0 when busy=0.
REQ-028 Completion: on the last HOLD cycle, the next edge SHALL deassert all chip selects, clear busy, pulse done=1 for exactly one cycle, and update rx_data.
REQ-029 Transfer length SHALL be exactly CLK_DIV*(2*DATA_WIDTH+2) busy cycles.
REQ-030 rx_data SHALL hold its value between transfers and SHALL assemble bits in the order set by MSB_FIRST.
REQ-031 A start asserted in the cycle where done=1 (busy=0) SHALL be accepted, giving back-to-back transfers with one idle cycle and chip select high for that cycle.

Reset
REQ-032 reset=0 SHALL immediately, without waiting for clk, force:
- state=IDLE, busy=0, done=0
- spi_cs_l all ones, spi_sclk=CPOL, spi_mosi=0
- rx_data=0, counter=0
REQ-033 A reset during a transfer SHALL abort it with no done pulse; the first start after release SHALL begin a fresh transfer.

Verification
REQ-034 Defaults, spi_miso looped to spi_mosi, tx_data=16'hA5C3, cs_sel=0, start at T0 -> spi_cs_l=2'b10 from T0+1, 16 sclk pulses, done at T0+69, rx_data=16'hA5C3.
REQ-035 CPOL=1, CPHA=1, MSB_FIRST=0, DATA_WIDTH=8, slave model drives 8'h3C -> spi_mosi carries 8'h96 LSB-first, sclk idles high, rx_data=8'h3C.
REQ-036 start pulsed mid-transfer with a new tx_data -> ignored, busy unchanged, one done only, original data shifted.
REQ-037 reset=0 at half-way through the transfer -> spi_cs_l=all ones asynchronously, no done, a later start completes normally.
REQ-038 cs_sel=1, then start re-asserted during the done cycle -> two transfers; spi_cs_l[1] low during each, high for one cycle between them.
REQ-039 CLK_DIV=1 and CLK_DIV=5 -> busy lasts 34 and 170 cycles for DATA_WIDTH=16, with data correct.
